// File: rtl/render_pkg.sv
// Shared definitions for the board renderers: colour codes, renderer FSM states
// and the board dimension.
package render_pkg;

  localparam int GRID_N = 8;

  localparam logic [2:0] COL_LINE      = 3'b000;
  localparam logic [2:0] COL_EMPTY     = 3'b001;
  localparam logic [2:0] COL_FILLED    = 3'b111;
  localparam logic [2:0] COL_FILLED_GO = 3'b101;
  localparam logic [2:0] COL_GHOST     = 3'b010;
  localparam logic [2:0] COL_CONFLICT  = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/grid_cell_shader.sv
// Combinational colour lookup for one pixel of an 8x8 board cell, given the
// board occupancy, the selected-block overlay and the game-over flag.
module grid_cell_shader
  import render_pkg::*;
#(
  parameter int PX_W = 4
) (
  input  logic [2:0]      i_cr,
  input  logic [2:0]      i_cc,
  input  logic [PX_W-1:0] i_px,
  input  logic [PX_W-1:0] i_py,
  input  logic [63:0]     i_grid,
  input  logic [63:0]     i_mask,
  input  logic [2:0]      i_sel_x,
  input  logic [2:0]      i_sel_y,
  input  logic            i_game_over,
  output logic [2:0]      o_colour
);

  logic [2:0] w_dr;
  logic [2:0] w_dc;
  logic       w_filled;
  logic       w_ov;

  // Offsets into the mask are only meaningful when non-negative; both stay <= 7
  // so any in-range offset lands inside the 8x8 mask.
  assign w_dr     = i_cr - i_sel_y;
  assign w_dc     = i_cc - i_sel_x;
  assign w_filled = i_grid[{i_cr, i_cc}];
  assign w_ov     = !i_game_over && (i_cr >= i_sel_y) && (i_cc >= i_sel_x)
                    && i_mask[{w_dr, w_dc}];

  always_comb begin
    o_colour = COL_EMPTY;
    if (i_px == '0 || i_py == '0)
      o_colour = COL_LINE;
    else if (w_ov && w_filled)
      o_colour = COL_CONFLICT;
    else if (w_ov)
      o_colour = COL_GHOST;
    else if (w_filled)
      o_colour = i_game_over ? COL_FILLED_GO : COL_FILLED;
  end

endmodule

// File: rtl/grid_renderer.sv
// Snapshots the game state on request and streams one raster pass of the 8x8
// board as pixel writes over a valid/ready plot interface.
module grid_renderer
  import render_pkg::*;
#(
  parameter int CELL_PX  = 12,
  parameter int ORIGIN_X = 32,
  parameter int ORIGIN_Y = 12
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        frame_req,
  input  logic [63:0] game_grid,
  input  logic [63:0] sel_block,
  input  logic [2:0]  sel_x,
  input  logic [2:0]  sel_y,
  input  logic        game_over,
  input  logic        plot_ready,
  output logic        plot_valid,
  output logic [7:0]  plot_x,
  output logic [6:0]  plot_y,
  output logic [2:0]  plot_colour,
  output logic        busy,
  output logic        frame_done
);

  localparam int              PX_W    = $clog2(CELL_PX);
  localparam logic [PX_W-1:0] PX_LAST = PX_W'(CELL_PX - 1);
  localparam logic [2:0]      C_LAST  = 3'(GRID_N - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_pending;
  logic [2:0]      r_cc;
  logic [2:0]      r_cr;
  logic [PX_W-1:0] r_px;
  logic [PX_W-1:0] r_py;
  logic [63:0]     r_grid;
  logic [63:0]     r_mask;
  logic [2:0]      r_sel_x;
  logic [2:0]      r_sel_y;
  logic            r_game_over;

  logic            w_start;
  logic            w_valid;
  logic            w_fire;
  logic            w_row_end;
  logic            w_last;
  logic [2:0]      w_colour;

  assign w_valid   = (r_state == DRAW);
  assign w_fire    = w_valid && plot_ready;
  assign w_row_end = (r_cc == C_LAST) && (r_px == PX_LAST);
  assign w_last    = w_row_end && (r_cr == C_LAST) && (r_py == PX_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    case (r_state)
      IDLE: if (r_pending) begin
        w_start     = 1'b1;
        w_state_nxt = DRAW;
      end
      DRAW: if (w_fire && w_last) w_state_nxt = DONE;
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Every request lands in r_pending first; IDLE launches from it, so requests
  // during DRAW/DONE collapse into a single follow-on frame.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)        r_pending <= 1'b0;
    else if (frame_req) r_pending <= 1'b1;
    else if (w_start)   r_pending <= 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_grid      <= '0;
      r_mask      <= '0;
      r_sel_x     <= '0;
      r_sel_y     <= '0;
      r_game_over <= 1'b0;
    end else if (w_start) begin
      r_grid      <= game_grid;
      r_mask      <= sel_block;
      r_sel_x     <= sel_x;
      r_sel_y     <= sel_y;
      r_game_over <= game_over;
    end
  end

  // The row counter wraps 7->0 on the final pixel, leaving all counters at zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_px <= '0;
      r_cc <= '0;
      r_py <= '0;
      r_cr <= '0;
    end else if (w_fire) begin
      if (w_row_end) begin
        r_px <= '0;
        r_cc <= '0;
        if (r_py == PX_LAST) begin
          r_py <= '0;
          r_cr <= r_cr + 3'd1;
        end else begin
          r_py <= r_py + 1'b1;
        end
      end else if (r_px == PX_LAST) begin
        r_px <= '0;
        r_cc <= r_cc + 3'd1;
      end else begin
        r_px <= r_px + 1'b1;
      end
    end
  end

  grid_cell_shader #(.PX_W(PX_W)) u_shader (
    .i_cr        (r_cr),
    .i_cc        (r_cc),
    .i_px        (r_px),
    .i_py        (r_py),
    .i_grid      (r_grid),
    .i_mask      (r_mask),
    .i_sel_x     (r_sel_x),
    .i_sel_y     (r_sel_y),
    .i_game_over (r_game_over),
    .o_colour    (w_colour)
  );

  assign plot_valid  = w_valid;
  assign plot_x      = w_valid ? 8'(9'(ORIGIN_X) + 9'(r_cc) * 9'(CELL_PX) + 9'(r_px)) : 8'd0;
  assign plot_y      = w_valid ? 7'(9'(ORIGIN_Y) + 9'(r_cr) * 9'(CELL_PX) + 9'(r_py)) : 7'd0;
  assign plot_colour = w_valid ? w_colour : 3'b000;
  assign busy        = w_valid;
  assign frame_done  = (r_state == DONE);

endmodule

// File: tb/tb_grid_renderer.sv
// Self-checking bench for grid_renderer: full-frame raster checks against a
// pixel-coordinate colour model, stalls, follow-on frames and reset abort.
module tb_grid_renderer;

  localparam int CELL = 12;
  localparam int OX   = 32;
  localparam int OY   = 12;
  localparam int SIDE = 8 * CELL;
  localparam int NPIX = SIDE * SIDE;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_req = 1'b0;
  logic [63:0] game_grid = '0;
  logic [63:0] sel_block = '0;
  logic [2:0]  sel_x = '0;
  logic [2:0]  sel_y = '0;
  logic        game_over = 1'b0;
  logic        plot_ready = 1'b1;
  logic        plot_valid;
  logic [7:0]  plot_x;
  logic [6:0]  plot_y;
  logic [2:0]  plot_colour;
  logic        busy;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  logic [2:0] cap     [NPIX];
  logic [2:0] cap_ref [NPIX];

  grid_renderer #(.CELL_PX(CELL), .ORIGIN_X(OX), .ORIGIN_Y(OY)) dut (
    .clk(clk), .resetn(resetn), .frame_req(frame_req), .game_grid(game_grid),
    .sel_block(sel_block), .sel_x(sel_x), .sel_y(sel_y), .game_over(game_over),
    .plot_ready(plot_ready), .plot_valid(plot_valid), .plot_x(plot_x),
    .plot_y(plot_y), .plot_colour(plot_colour), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Colour of the idx-th pixel of a raster pass, derived from board geometry.
  function automatic logic [2:0] model_colour(input int idx, input logic [63:0] g,
      input logic [63:0] m, input int sx, input int sy, input logic go);
    int x, y, cc, cr, px, py;
    logic filled, ov;
    x = idx % SIDE;  y = idx / SIDE;
    cc = x / CELL;   px = x % CELL;
    cr = y / CELL;   py = y % CELL;
    if (px == 0 || py == 0) return 3'b000;
    filled = g[cr*8 + cc];
    ov = 1'b0;
    if (!go && cr >= sy && cc >= sx) ov = m[(cr-sy)*8 + (cc-sx)];
    if (ov && filled) return 3'b100;
    if (ov)           return 3'b010;
    if (filled)       return go ? 3'b101 : 3'b111;
    return 3'b001;
  endfunction

  task automatic stream_frame(input logic [63:0] g, input logic [63:0] m,
      input logic [2:0] sx, input logic [2:0] sy, input logic go, input bit rnd,
      input bit pulse, input bit extra, input logic [63:0] gmid, input string tag);
    int n_acc = 0;
    int t = 0;
    int lim = 4 * NPIX + 50;
    bit held = 0;
    bit abort = 0;
    bit rdy;
    int ex, ey;
    logic [2:0] ec, hc;
    logic [7:0] hx, lx;
    logic [6:0] hy, ly;
    game_grid = g; sel_block = m; sel_x = sx; sel_y = sy; game_over = go;
    plot_ready = 1'b1;
    if (pulse) begin
      @(negedge clk) frame_req = 1'b1;
      @(negedge clk) frame_req = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
        errors++; $display("FAIL %s latency_early busy=%0d want 0", tag, busy);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1 || plot_valid !== 1'b1 || plot_x !== 8'(OX) || plot_y !== 7'(OY)) begin
        errors++;
        $display("FAIL %s latency_start busy=%0d valid=%0d (%0d,%0d) want 1 1 (%0d,%0d)",
                 tag, busy, plot_valid, plot_x, plot_y, OX, OY);
      end
    end
    while (n_acc < NPIX && t < lim && !abort) begin
      frame_req = 1'b0;
      if (held) begin
        checks++;
        if (plot_valid !== 1'b1 || plot_x !== hx || plot_y !== hy || plot_colour !== hc) begin
          errors++;
          $display("FAIL %s stall_hold pix%0d got v%0d (%0d,%0d) c%0d want v1 (%0d,%0d) c%0d",
                   tag, n_acc, plot_valid, plot_x, plot_y, plot_colour, hx, hy, hc);
        end
      end
      if (plot_valid === 1'b1) begin
        if (!held) begin
          ex = OX + n_acc % SIDE;
          ey = OY + n_acc / SIDE;
          ec = model_colour(n_acc, g, m, sx, sy, go);
          checks++;
          if (plot_x !== 8'(ex) || plot_y !== 7'(ey) || plot_colour !== ec) begin
            errors++;
            $display("FAIL %s pixel%0d got (%0d,%0d) c%0d want (%0d,%0d) c%0d",
                     tag, n_acc, plot_x, plot_y, plot_colour, ex, ey, ec);
          end
        end
        rdy = rnd ? ($urandom_range(3) != 0) : 1'b1;
        plot_ready = rdy;
        if (rdy) begin
          cap[n_acc] = plot_colour;
          lx = plot_x; ly = plot_y;
          n_acc++;
          held = 0;
        end else begin
          held = 1; hx = plot_x; hy = plot_y; hc = plot_colour;
        end
        if (extra && (n_acc == 100 || n_acc == 200 || n_acc == 300)) frame_req = 1'b1;
        if (extra && n_acc == 400) game_grid = gmid;
      end else if (n_acc > 0 || held) begin
        checks++; errors++;
        $display("FAIL %s valid_drop at pix%0d valid=%0d want 1", tag, n_acc, plot_valid);
        abort = 1;
      end
      if (!abort && n_acc < NPIX) begin
        @(negedge clk);
        t++;
      end
    end
    frame_req = 1'b0;
    checks++;
    if (n_acc != NPIX) begin
      errors++; $display("FAIL %s accept_count got %0d want %0d", tag, n_acc, NPIX);
    end else begin
      checks++;
      if (lx !== 8'd127 || ly !== 7'd107) begin
        errors++; $display("FAIL %s last_pixel got (%0d,%0d) want (127,107)", tag, lx, ly);
      end
      @(negedge clk);
      plot_ready = 1'b1;
      checks++;
      if (frame_done !== 1'b1 || plot_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL %s frame_end done=%0d valid=%0d busy=%0d want 1 0 0",
                 tag, frame_done, plot_valid, busy);
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (plot_valid !== 0 || plot_x !== 0 || plot_y !== 0 || plot_colour !== 0 ||
        busy !== 0 || frame_done !== 0) begin
      errors++;
      $display("FAIL reset_state v%0d (%0d,%0d) c%0d busy%0d done%0d want all 0",
               plot_valid, plot_x, plot_y, plot_colour, busy, frame_done);
    end
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 0 || plot_valid !== 0) begin
      errors++; $display("FAIL idle_after_reset busy=%0d valid=%0d want 0 0", busy, plot_valid);
    end
  endtask

  task automatic test_empty();
    stream_frame('0, '0, 3'd0, 3'd0, 1'b0, 0, 1, 0, '0, "empty");
    checks++;
    if (cap[0] !== 3'd0) begin
      errors++; $display("FAIL empty_first_colour got %0d want 0", cap[0]);
    end
    checks++;
    if (cap[SIDE+1] !== 3'd1) begin
      errors++; $display("FAIL empty_33_13 got %0d want 1", cap[SIDE+1]);
    end
  endtask

  task automatic test_overlay();
    stream_frame(64'h1, 64'h3, 3'd0, 3'd0, 1'b0, 0, 1, 0, '0, "overlay");
    cap_ref = cap;
    checks++;
    if (cap[SIDE+1] !== 3'd4) begin
      errors++; $display("FAIL conflict_33_13 got %0d want 4", cap[SIDE+1]);
    end
    checks++;
    if (cap[SIDE+13] !== 3'd2) begin
      errors++; $display("FAIL ghost_45_13 got %0d want 2", cap[SIDE+13]);
    end
    checks++;
    if (cap[SIDE+25] !== 3'd1) begin
      errors++; $display("FAIL empty_57_13 got %0d want 1", cap[SIDE+25]);
    end
  endtask

  task automatic test_game_over();
    stream_frame(64'h1, 64'h3, 3'd0, 3'd0, 1'b1, 0, 1, 0, '0, "gameover");
    checks++;
    if (cap[SIDE+1] !== 3'd5) begin
      errors++; $display("FAIL go_filled_33_13 got %0d want 5", cap[SIDE+1]);
    end
    checks++;
    if (cap[SIDE+13] !== 3'd1) begin
      errors++; $display("FAIL go_no_ghost_45_13 got %0d want 1", cap[SIDE+13]);
    end
  endtask

  task automatic test_stall();
    int ndiff = 0;
    stream_frame(64'h1, 64'h3, 3'd0, 3'd0, 1'b0, 1, 1, 0, '0, "stall");
    for (int i = 0; i < NPIX; i++) if (cap[i] !== cap_ref[i]) ndiff++;
    checks++;
    if (ndiff !== 0) begin
      errors++; $display("FAIL stall_sequence differing pixels got %0d want 0", ndiff);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] g, m, gmid;
    logic [2:0] sx, sy;
    int seen = 0;
    g = {$urandom, $urandom};
    m = {$urandom, $urandom};
    sx = 3'($urandom_range(7));
    sy = 3'($urandom_range(7));
    gmid = ~g;
    stream_frame(g, m, sx, sy, 1'b0, 0, 1, 1, gmid, "b2b_first");
    @(negedge clk);
    checks++;
    if (busy !== 0 || plot_valid !== 0 || frame_done !== 0) begin
      errors++; $display("FAIL b2b_idle_gap busy=%0d valid=%0d done=%0d want 0 0 0",
                         busy, plot_valid, frame_done);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1 || plot_valid !== 1 || plot_x !== 8'(OX) || plot_y !== 7'(OY)) begin
      errors++; $display("FAIL b2b_restart busy=%0d valid=%0d (%0d,%0d) want 1 1 (%0d,%0d)",
                         busy, plot_valid, plot_x, plot_y, OX, OY);
    end
    stream_frame(gmid, m, sx, sy, 1'b0, 0, 0, 0, gmid, "b2b_second");
    repeat (6) begin
      @(negedge clk);
      if (busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL b2b_no_third busy_cycles got %0d want 0", seen);
    end
  endtask

  task automatic test_reset_abort();
    game_grid = {$urandom, $urandom};
    sel_block = {$urandom, $urandom};
    sel_x = 3'($urandom_range(7));
    sel_y = 3'($urandom_range(7));
    game_over = 1'b0;
    plot_ready = 1'b1;
    @(negedge clk) frame_req = 1'b1;
    @(negedge clk) frame_req = 1'b0;
    @(negedge clk);
    repeat (500) @(negedge clk);
    checks++;
    if (plot_valid !== 1 || plot_x !== 8'(OX + 500 % SIDE) || plot_y !== 7'(OY + 500 / SIDE)) begin
      errors++; $display("FAIL abort_pix500 v%0d (%0d,%0d) want v1 (%0d,%0d)",
                         plot_valid, plot_x, plot_y, OX + 500 % SIDE, OY + 500 / SIDE);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (plot_valid !== 0 || busy !== 0 || plot_x !== 0 || plot_y !== 0 ||
        plot_colour !== 0 || frame_done !== 0) begin
      errors++; $display("FAIL abort_reset v%0d busy%0d (%0d,%0d) c%0d done%0d want all 0",
                         plot_valid, busy, plot_x, plot_y, plot_colour, frame_done);
    end
    @(negedge clk) resetn = 1'b1;
    @(negedge clk) frame_req = 1'b1;
    @(negedge clk) frame_req = 1'b0;
    @(negedge clk);
    checks++;
    if (plot_valid !== 1 || plot_x !== 8'(OX) || plot_y !== 7'(OY) || plot_colour !== 3'd0) begin
      errors++; $display("FAIL abort_restart v%0d (%0d,%0d) c%0d want v1 (%0d,%0d) c0",
                         plot_valid, plot_x, plot_y, plot_colour, OX, OY);
    end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_overlay();
    test_game_over();
    test_stall();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/grid_renderer.md
Name: grid_renderer

Overview:
- Reader of the game-state outputs: on request, snapshots the 8x8 board, selected-block mask and position, and game_over.
- Streams one raster pass of the board as pixel writes into the VGA framebuffer adapter over a valid/ready plot interface.
- Sits between the game logic and the VGA adapter in the top level; the top level muxes the selected block and its x/y into this block.

Parameters:
- CELL_PX, 12, side of one board cell in pixels (>=2).
- ORIGIN_X, 32, framebuffer x of board top-left pixel.
- ORIGIN_Y, 12, framebuffer y of board top-left pixel.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- frame_req  in  1  one-cycle pulse: draw a frame
- game_grid  in  64  board occupancy, bit r*8+c = row r, column c
- sel_block  in  64  selected block mask, same layout, anchored at (sel_x, sel_y)
- sel_x  in  3  selected block column offset
- sel_y  in  3  selected block row offset
- game_over  in  1  game-over flag
- plot_ready  in  1  adapter accepts the pixel this cycle
- plot_valid  out  1  pixel presented
- plot_x  out  8  framebuffer x
- plot_y  out  7  framebuffer y
- plot_colour  out  3  RGB, 1 bit each
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (async, resetn=0): state IDLE, plot_valid=0, plot_x=0, plot_y=0, plot_colour=0, busy=0, frame_done=0, pending=0. All counters cleared.
- Reset mid-frame aborts the frame immediately. No partial pixel is held.
- States:
  - IDLE: on frame_req or pending, snapshot all inputs into registers, clear pending, go to DRAW.
  - DRAW: streams pixels.
  - DONE: one cycle; frame_done=1, then return to IDLE.
- Latency: frame_req sampled high at edge N gives, after edge N+1, busy=1, plot_valid=1, plot_x=ORIGIN_X, plot_y=ORIGIN_Y.
- Raster order, row-major over the 8*CELL_PX square: x fastest, then y.
- Counters: cell column cc, in-cell x px, cell row cr, in-cell y py.
  - px wraps at CELL_PX-1 and increments cc.
  - After cc=7/px=CELL_PX-1, cc and px reset and py increments.
  - py wraps into cr.
- Handshake:
  - Counters advance only on plot_valid && plot_ready.
  - plot_x, plot_y, plot_colour are stable while plot_valid=1 && plot_ready=0.
  - plot_valid never drops mid-frame.
- Last pixel: when the pixel at (ORIGIN_X+8*CELL_PX-1, ORIGIN_Y+8*CELL_PX-1) is accepted, the next cycle has plot_valid=0, state DONE, frame_done=1, busy=0.
- Total accepted pixels per frame: 64*CELL_PX^2 (9216 at default).
- Colour per pixel, using snapshot values:
  - Grid line: px==0 or py==0 gives 3'b000.
  - Overlay ov(cr,cc) = !game_over && cr>=sel_y && cc>=sel_x && sel_block[(cr-sel_y)*8+(cc-sel_x)]. Cells beyond the mask (index past row/col 7) are not overlay.
  - ov && grid filled: CONFLICT 3'b100.
  - ov only: GHOST 3'b010.
  - Grid filled only: FILLED 3'b111, or 3'b101 when game_over.
  - Otherwise EMPTY 3'b001.
- Inputs changing during DRAW have no effect on the current frame.
- frame_req while busy or in DONE sets pending. Any number of such requests collapse into one follow-on frame, which starts from IDLE the cycle after DONE.
- plot_x/plot_y are computed as ORIGIN + cell*CELL_PX + offset in 9-bit arithmetic, then truncated to port width. Callers must choose parameters so the board fits in 160x120.

Decomposition:
- Shared package render_pkg:
  - colour constants COL_LINE, COL_EMPTY, COL_FILLED, COL_FILLED_GO, COL_GHOST, COL_CONFLICT;
  - state encoding IDLE/DRAW/DONE;
  - GRID_N=8.
- One natural sub-module: grid_cell_shader. It is combinational, maps (cr, cc, px, py, snapshot grid/mask/x/y/game_over) to colour, and is reused by a future tray renderer.

Test Plan:
- Empty grid, sel_block=0, plot_ready=1, frame_req pulse:
  - first pixel (32,12) colour 0;
  - pixel (33,13) colour 1;
  - exactly 9216 accepts;
  - frame_done one cycle after last pixel (127,107).
- game_grid bit 0 set, sel_block=bits{0,1}, sel_x=0, sel_y=0:
  - pixel (33,13) colour 4 (conflict);
  - pixel (45,13) colour 2 (ghost);
  - pixel (57,13) colour 1.
- Same as above with game_over=1: pixel (33,13) colour 5, pixel (45,13) colour 1.
- plot_ready toggled pseudo-randomly:
  - outputs held stable while stalled;
  - pixel sequence identical to the ready=1 run;
  - still exactly 9216 accepts.
- Three frame_req pulses during busy: exactly one extra frame follows, starting the cycle after frame_done; game_grid changed mid-frame appears only in the second frame.
- resetn asserted at pixel 500: plot_valid=0 and busy=0 immediately; a new frame_req restarts at (32,12).
